// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, LSB first, 1 start and 1 stop bit, with midpoint sampling.
// Define UART_RX_PARITY_EN to expect an even-parity bit between bit 7 and the stop bit.
module uart_rx #(
    parameter int SYS_CLOCK = 1000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_input,
    output logic [7:0] data_output,
    output logic       data_valid,
    output logic       busy,
    output logic       frame_error,
    output logic       parity_error
);

    localparam int CLKS_PER_BIT = SYS_CLOCK / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         sync_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic               ferr_q, ferr_d;
    logic               rx_s;
    logic               bit_done;
`ifdef UART_RX_PARITY_EN
    logic               par_bad_q, par_bad_d;
    logic               perr_q, perr_d;
`endif

    assign rx_s = sync_q[1];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= 2'b11;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            sync_q    <= {sync_q[0], rx_input};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        bit_done  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
                    // A start bit that has gone high again by its midpoint was a glitch.
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    cnt_d     = '0;
                    par_bad_d = (rx_s != ^shift_q);
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end else begin
                        state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad_q) begin
                            perr_d = 1'b1;
                        end else begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
`else
                        data_d  = shift_q;
                        valid_d = 1'b1;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign data_output = data_q;
    assign data_valid  = valid_q;
    assign frame_error = ferr_q;
    assign busy        = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_error = perr_q;
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at the default 104 clocks per bit.
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx;

    localparam int BIT = 104;
`ifdef UART_RX_PARITY_EN
    localparam int VALID_LAT = 3 + 52 + 10 * BIT;
`else
    localparam int VALID_LAT = 3 + 52 + 9 * BIT;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_input;
    logic [7:0] data_output;
    logic       data_valid;
    logic       busy;
    logic       frame_error;
    logic       parity_error;

    uart_rx dut (
        .clk          (clk),
        .reset        (reset),
        .rx_input     (rx_input),
        .data_output  (data_output),
        .data_valid   (data_valid),
        .busy         (busy),
        .frame_error  (frame_error),
        .parity_error (parity_error)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          valid_cnt = 0;
    int          ferr_cnt = 0;
    int          perr_cnt = 0;
    int          last_valid_cyc = 0;
    logic [7:0]  rx_bytes[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge away from the active edge.
    always @(negedge clk) begin
        if (data_valid) begin
            valid_cnt      = valid_cnt + 1;
            last_valid_cyc = cyc;
            rx_bytes.push_back(data_output);
        end
        if (frame_error)  ferr_cnt = ferr_cnt + 1;
        if (parity_error) perr_cnt = perr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; leaves the line at b for n cycles.
    task automatic send_bit(input logic b, input int n);
        rx_input = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_data(input logic [7:0] d);
        send_bit(1'b0, BIT);
        for (int i = 0; i < 8; i++) send_bit(d[i], BIT);
`ifdef UART_RX_PARITY_EN
        send_bit(^d, BIT);
`endif
    endtask

    task automatic send_frame(input logic [7:0] d);
        send_data(d);
        send_bit(1'b1, BIT);
    endtask

    int         start_cyc;
    int         v0;
    int         f0;
    logic [7:0] a5;

    initial begin
        reset    = 1'b0;
        rx_input = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_data",  data_output, 8'h00);
        check("rst_valid", data_valid, 1'b0);
        check("rst_busy",  busy, 1'b0);
        check("rst_ferr",  frame_error, 1'b0);
        check("rst_perr",  parity_error, 1'b0);
        reset = 1'b1;

        // Idle line.
        repeat (2000) @(negedge clk);
        check("idle_busy",  busy, 1'b0);
        check("idle_valid", valid_cnt, 0);
        check("idle_data",  data_output, 8'h00);

        // Single frame with latency check on the valid strobe.
        start_cyc = cyc;
        send_frame(8'hA5);
        repeat (20) @(negedge clk);
        check("a5_count", valid_cnt, 1);
        check("a5_data",  data_output, 8'hA5);
        check("a5_lat",   last_valid_cyc - start_cyc, VALID_LAT);
        check("a5_ferr",  ferr_cnt, 0);
        check("a5_busy",  busy, 1'b0);

        // Back-to-back frames with no idle gap.
        send_frame(8'h3C);
        send_frame(8'hFF);
        repeat (20) @(negedge clk);
        check("b2b_count", valid_cnt, 3);
        check("b2b_first", rx_bytes[1], 8'h3C);
        check("b2b_second", rx_bytes[2], 8'hFF);
        check("b2b_data",  data_output, 8'hFF);

        // 30-cycle low glitch; busy rises 3 cycles after the line falls.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        rx_input = 1'b0;
        repeat (2) @(negedge clk);
        check("gl_busy_pre", busy, 1'b0);
        @(negedge clk);
        check("gl_busy_hi", busy, 1'b1);
        repeat (27) @(negedge clk);
        rx_input = 1'b1;
        repeat (100) @(negedge clk);
        check("gl_busy_lo", busy, 1'b0);
        check("gl_valid", valid_cnt, v0);
        check("gl_ferr",  ferr_cnt, f0);

        // Stop bit low, line held low into a break.
        send_data(8'h55);
        send_bit(1'b0, BIT + 500);
        check("fe_ferr",  ferr_cnt, f0 + 1);
        check("fe_valid", valid_cnt, v0);
        check("fe_data",  data_output, 8'hFF);
        check("fe_busy",  busy, 1'b1);
        send_bit(1'b1, 10);
        check("fe_idle",  busy, 1'b0);

        // Reset in the middle of data bit 4 of 8'hA5.
        a5 = 8'hA5;
        send_bit(1'b0, BIT);
        for (int i = 0; i < 4; i++) send_bit(a5[i], BIT);
        send_bit(a5[4], 50);
        reset    = 1'b0;
        rx_input = 1'b1;
        repeat (3) @(negedge clk);
        check("mr_data",  data_output, 8'h00);
        check("mr_busy",  busy, 1'b0);
        check("mr_valid", data_valid, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (1500) @(negedge clk);
        check("mr_nostrobe", valid_cnt, v0);
        check("mr_noferr",   ferr_cnt, f0 + 1);
        check("mr_idle",     busy, 1'b0);
        send_frame(8'h3C);
        repeat (20) @(negedge clk);
        check("mr_count", valid_cnt, v0 + 1);
        check("mr_after", data_output, 8'h3C);

`ifdef UART_RX_PARITY_EN
        // 8'h07 has odd weight, so even parity needs a 1; send 0 instead.
        v0 = valid_cnt;
        send_bit(1'b0, BIT);
        for (int i = 0; i < 8; i++) send_bit(i < 3, BIT);
        send_bit(1'b0, BIT);
        send_bit(1'b1, BIT);
        repeat (20) @(negedge clk);
        check("pe_perr",  perr_cnt, 1);
        check("pe_valid", valid_cnt, v0);
        check("pe_data",  data_output, 8'h3C);
`else
        check("no_perr", perr_cnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
